// File: rtl/n64_vmode_cfg_ctrl_pkg.sv
// rtl/n64_vmode_cfg_ctrl_pkg.sv - shared cfg bit indices, FSM encodings and masking helper
package n64_vmode_cfg_ctrl_pkg;

  // cfg word layout {linedbl_en, rgb15_en, deblur_en}
  localparam int CFG_W       = 3;
  localparam int CFG_DEBLUR  = 0;
  localparam int CFG_RGB15   = 1;
  localparam int CFG_LINEDBL = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_PUSH  = 2'd2,
    ST_DONE  = 2'd3
  } cfg_state_t;

  // Deblur is meaningless on interlaced content, so it is forced off there
  function automatic logic [CFG_W-1:0] mask_cfg(input logic [CFG_W-1:0] cfg,
                                                input logic             is_480i);
    logic [CFG_W-1:0] r;
    r = cfg;
    if (is_480i) r[CFG_DEBLUR] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/n64_mode_filter.sv
// rtl/n64_mode_filter.sv - per-frame {480i, vmode} debounce with change pulse
module n64_mode_filter #(
  parameter int STABLE_FRAMES = 4
) (
  input  logic       VCLK,
  input  logic       RST,
  input  logic       fb,
  input  logic [1:0] mode_in,
  output logic       vmode_stable,
  output logic       n64_480i_stable,
  output logic       mode_change,
  output logic       change_now,
  output logic       stable_480i_nxt
);

  localparam logic [2:0] STABLE_CNT = 3'(STABLE_FRAMES);

  logic [1:0] cand;
  logic [2:0] cnt;
  logic [2:0] cnt_nxt;

  // Saturating count of consecutive matching frames; a new mode restarts at 1
  always_comb begin
    cnt_nxt         = 3'd1;
    change_now      = 1'b0;
    stable_480i_nxt = n64_480i_stable;
    if (mode_in == cand) begin
      cnt_nxt = (cnt >= STABLE_CNT) ? STABLE_CNT : cnt + 3'd1;
    end
    if (fb && (cnt_nxt == STABLE_CNT) &&
        (mode_in != {n64_480i_stable, vmode_stable})) begin
      change_now      = 1'b1;
      stable_480i_nxt = mode_in[1];
    end
  end

  // Candidate/count update on each frame boundary, stable regs on accepted change
  always_ff @(posedge VCLK) begin
    if (RST) begin
      cand            <= 2'b10;
      cnt             <= 3'd0;
      vmode_stable    <= 1'b0;
      n64_480i_stable <= 1'b1;
      mode_change     <= 1'b0;
    end else begin
      mode_change <= change_now;
      if (fb) begin
        cand <= mode_in;
        cnt  <= cnt_nxt;
      end
      if (change_now) begin
        n64_480i_stable <= mode_in[1];
        vmode_stable    <= mode_in[0];
      end
    end
  end

endmodule

// File: rtl/n64_vmode_cfg_ctrl.sv
// rtl/n64_vmode_cfg_ctrl.sv - filtered video mode and frame-aligned cfg push to the pixel datapath
module n64_vmode_cfg_ctrl
  import n64_vmode_cfg_ctrl_pkg::*;
#(
  parameter int STABLE_FRAMES = 4,
  parameter int ACK_TIMEOUT   = 255
) (
  input  logic             VCLK,
  input  logic             RST,
  input  logic             nDSYNC,
  input  logic [3:0]       Sync_cur,
  input  logic [3:0]       vinfo_i,
  input  logic             cfg_req,
  input  logic [CFG_W-1:0] cfg_i,
  output logic             cfg_valid,
  output logic [CFG_W-1:0] cfg_o,
  input  logic             cfg_ack,
  output logic             vmode_stable,
  output logic             n64_480i_stable,
  output logic             mode_change,
  output logic             cfg_err
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

  cfg_state_t       state;
  cfg_state_t       state_nxt;
  logic [3:0]       Sync_pre;
  logic [CFG_W-1:0] target;
  logic [CFG_W-1:0] last_acked;
  logic [CFG_W-1:0] eff;
  logic [7:0]       timer;
  logic             pending;
  logic             fb;
  logic             launch;
  logic             acked;
  logic             timed_out;
  logic             change_now;
  logic             stable_480i_nxt;
  logic             unused_bits;

  assign unused_bits = ^{vinfo_i[3:2], Sync_cur[2:0], Sync_pre[2:0]};

  // Frame boundary is the falling edge of nVSYNC, seen only on data-sync cycles
  assign fb = ~nDSYNC & Sync_pre[3] & ~Sync_cur[3];

  // A same-cycle request bypasses into the launched word; masking uses the 480i flag valid after this edge
  assign eff = mask_cfg(cfg_req ? cfg_i : target, stable_480i_nxt);

  n64_mode_filter #(
    .STABLE_FRAMES (STABLE_FRAMES)
  ) u_mode_filter (
    .VCLK            (VCLK),
    .RST             (RST),
    .fb              (fb),
    .mode_in         (vinfo_i[1:0]),
    .vmode_stable    (vmode_stable),
    .n64_480i_stable (n64_480i_stable),
    .mode_change     (mode_change),
    .change_now      (change_now),
    .stable_480i_nxt (stable_480i_nxt)
  );

  // Previous sync nibble, captured only on data-sync cycles
  always_ff @(posedge VCLK) begin
    if (RST) Sync_pre <= 4'hF;
    else if (!nDSYNC) Sync_pre <= Sync_cur;
  end

  // FSM state register
  always_ff @(posedge VCLK) begin
    if (RST) state <= ST_IDLE;
    else state <= state_nxt;
  end

  // Next state and one-cycle control strobes for the handshake datapath
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    acked     = 1'b0;
    timed_out = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pending) state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (fb) begin
          state_nxt = ST_PUSH;
          launch    = 1'b1;
        end
      end
      ST_PUSH: begin
        if (cfg_ack) begin
          state_nxt = ST_DONE;
          acked     = 1'b1;
        end else if (timer == TIMEOUT_LAST) begin
          state_nxt = ST_DONE;
          timed_out = 1'b1;
        end
      end
      ST_DONE: begin
        state_nxt = pending ? ST_ARMED : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Target/pending bookkeeping and the valid/ack handshake with timeout fallback
  always_ff @(posedge VCLK) begin
    if (RST) begin
      target     <= '0;
      pending    <= 1'b0;
      cfg_valid  <= 1'b0;
      cfg_o      <= '0;
      last_acked <= '0;
      timer      <= 8'd0;
      cfg_err    <= 1'b0;
    end else begin
      if (cfg_req) target <= cfg_i;

      if (launch) pending <= 1'b0;
      else if (cfg_req || change_now) pending <= 1'b1;

      if (state == ST_PUSH) timer <= timer + 8'd1;

      if (launch) begin
        cfg_valid <= 1'b1;
        cfg_o     <= eff;
        timer     <= 8'd0;
      end

      if (acked) begin
        cfg_valid  <= 1'b0;
        last_acked <= cfg_o;
      end

      if (timed_out) begin
        cfg_valid <= 1'b0;
        cfg_err   <= 1'b1;
        cfg_o     <= last_acked;
      end
    end
  end

endmodule

// File: tb/tb_n64_vmode_cfg_ctrl.sv
// tb/tb_n64_vmode_cfg_ctrl.sv - directed scoreboard bench for n64_vmode_cfg_ctrl
module tb_n64_vmode_cfg_ctrl;

  localparam int STABLE_FRAMES = 4;
  localparam int ACK_TIMEOUT   = 255;

  logic       VCLK     = 1'b0;
  logic       RST      = 1'b1;
  logic       nDSYNC   = 1'b0;
  logic [3:0] Sync_cur = 4'hF;
  logic [3:0] vinfo_i  = 4'h0;
  logic       cfg_req  = 1'b0;
  logic [2:0] cfg_i    = 3'b000;
  logic       cfg_ack  = 1'b0;
  logic       cfg_valid;
  logic [2:0] cfg_o;
  logic       vmode_stable;
  logic       n64_480i_stable;
  logic       mode_change;
  logic       cfg_err;

  int         n_cmp      = 0;
  int         n_err      = 0;
  int         width      = 0;
  int         last_width = 0;
  int         mc_count   = 0;
  int         mc_base    = 0;
  logic       prev_valid = 1'b0;
  logic [2:0] held_o     = 3'b000;
  logic [2:0] sb[$];

  n64_vmode_cfg_ctrl #(
    .STABLE_FRAMES (STABLE_FRAMES),
    .ACK_TIMEOUT   (ACK_TIMEOUT)
  ) dut (
    .VCLK            (VCLK),
    .RST             (RST),
    .nDSYNC          (nDSYNC),
    .Sync_cur        (Sync_cur),
    .vinfo_i         (vinfo_i),
    .cfg_req         (cfg_req),
    .cfg_i           (cfg_i),
    .cfg_valid       (cfg_valid),
    .cfg_o           (cfg_o),
    .cfg_ack         (cfg_ack),
    .vmode_stable    (vmode_stable),
    .n64_480i_stable (n64_480i_stable),
    .mode_change     (mode_change),
    .cfg_err         (cfg_err)
  );

  always #5 VCLK = ~VCLK;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop an expected word on every rising cfg_valid, then watch it is held
  always @(negedge VCLK) begin
    if (mode_change === 1'b1) mc_count++;
    if (cfg_valid === 1'b1 && !prev_valid) begin
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_err++;
        $error("FAIL push_unexpected observed=%0d expected=no_push", cfg_o);
      end
      if (sb.size() != 0) chk("push_cfg_o", int'(cfg_o), int'(sb.pop_front()));
      held_o = cfg_o;
      width  = 1;
    end else if (cfg_valid === 1'b1) begin
      chk("cfg_o_held", int'(cfg_o), int'(held_o));
      width++;
    end else if (prev_valid) begin
      last_width = width;
    end
    prev_valid = (cfg_valid === 1'b1);
  end

  // One frame: nVSYNC high for 3 cycles then falls; returns one cycle after the fb edge
  task automatic do_fb(input logic [1:0] m, input logic req, input logic [2:0] cfg);
    Sync_cur = 4'hF;
    vinfo_i  = {2'b00, m};
    repeat (3) @(negedge VCLK);
    Sync_cur = 4'h7;
    if (req) begin
      cfg_req = 1'b1;
      cfg_i   = cfg;
    end
    @(negedge VCLK);
    cfg_req = 1'b0;
  endtask

  task automatic do_req(input logic [2:0] cfg);
    cfg_req = 1'b1;
    cfg_i   = cfg;
    @(negedge VCLK);
    cfg_req = 1'b0;
  endtask

  task automatic ack_push(input int d);
    repeat (d) @(negedge VCLK);
    cfg_ack = 1'b1;
    @(negedge VCLK);
    cfg_ack = 1'b0;
    chk("valid_fall_on_ack", int'(cfg_valid), 0);
    @(negedge VCLK);
    chk("valid_width", last_width, d + 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, int'(cfg_valid), 0);
    chk({tag, "_cfg_o"}, int'(cfg_o), 0);
    chk({tag, "_vmode"}, int'(vmode_stable), 0);
    chk({tag, "_480i"}, int'(n64_480i_stable), 1);
    chk({tag, "_mc"}, int'(mode_change), 0);
    chk({tag, "_err"}, int'(cfg_err), 0);
  endtask

  initial begin
    // Reset
    repeat (3) @(negedge VCLK);
    chk_reset_outputs("reset");
    RST = 1'b0;
    @(negedge VCLK);

    // Four NTSC progressive frames: one mode_change on the 4th, then a forced push of 000
    for (int i = 0; i < 3; i++) begin
      do_fb(2'b00, 1'b0, 3'b000);
      chk("ntsc_no_mc_early", int'(mode_change), 0);
    end
    do_fb(2'b00, 1'b0, 3'b000);
    chk("ntsc_mc_4th", int'(mode_change), 1);
    chk("ntsc_vmode", int'(vmode_stable), 0);
    chk("ntsc_480i", int'(n64_480i_stable), 0);
    @(negedge VCLK);
    chk("ntsc_mc_one_cycle", int'(mode_change), 0);
    chk("ntsc_mc_count", mc_count, 1);
    sb.push_back(3'b000);
    do_fb(2'b00, 1'b0, 3'b000);
    chk("forced_push_latency", int'(cfg_valid), 1);
    ack_push(2);

    // Alternating PAL/NTSC never settles
    mc_base = mc_count;
    for (int i = 0; i < 20; i++) begin
      do_fb((i % 2 == 0) ? 2'b01 : 2'b00, 1'b0, 3'b000);
    end
    @(negedge VCLK);
    chk("alt_mc_none", mc_count, mc_base);
    chk("alt_vmode_kept", int'(vmode_stable), 0);
    chk("alt_480i_kept", int'(n64_480i_stable), 0);
    chk("alt_no_push", int'(cfg_valid), 0);

    // 480i becomes stable with a 111 request on the same fb: one push of 110
    for (int i = 0; i < 3; i++) do_fb(2'b10, 1'b0, 3'b000);
    do_fb(2'b10, 1'b1, 3'b111);
    chk("i480_mc", int'(mode_change), 1);
    chk("i480_stable", int'(n64_480i_stable), 1);
    sb.push_back(3'b110);
    do_fb(2'b10, 1'b0, 3'b000);
    chk("i480_valid", int'(cfg_valid), 1);
    chk("i480_cfg_o", int'(cfg_o), 3'b110);
    ack_push(3);
    chk("i480_cfg_o_after", int'(cfg_o), 3'b110);
    do_fb(2'b10, 1'b0, 3'b000);
    chk("i480_no_repush", int'(cfg_valid), 0);

    // Back to 240p, two requests before the fb: single push of the later one
    for (int i = 0; i < 4; i++) do_fb(2'b00, 1'b0, 3'b000);
    chk("p240_stable", int'(n64_480i_stable), 0);
    do_req(3'b001);
    do_req(3'b100);
    sb.push_back(3'b100);
    do_fb(2'b00, 1'b0, 3'b000);
    chk("p240_valid", int'(cfg_valid), 1);
    ack_push(1);
    do_fb(2'b00, 1'b0, 3'b000);
    chk("p240_single_push", int'(cfg_valid), 0);

    // No ack: timeout, sticky error, revert to last acked, later push still works
    do_req(3'b011);
    sb.push_back(3'b011);
    do_fb(2'b00, 1'b0, 3'b000);
    chk("to_valid", int'(cfg_valid), 1);
    for (int i = 0; i < ACK_TIMEOUT + 20 && cfg_valid === 1'b1; i++) @(negedge VCLK);
    chk("to_valid_fell", int'(cfg_valid), 0);
    chk("to_err", int'(cfg_err), 1);
    chk("to_revert", int'(cfg_o), 3'b100);
    @(negedge VCLK);
    chk("to_width", last_width, ACK_TIMEOUT);
    do_req(3'b010);
    sb.push_back(3'b010);
    do_fb(2'b00, 1'b0, 3'b000);
    chk("to_repush_valid", int'(cfg_valid), 1);
    ack_push(0);
    chk("to_err_sticky", int'(cfg_err), 1);
    chk("to_repush_cfg_o", int'(cfg_o), 3'b010);

    // Reset during a push with a request queued behind it
    do_req(3'b101);
    sb.push_back(3'b101);
    do_fb(2'b00, 1'b0, 3'b000);
    chk("rst_push_valid", int'(cfg_valid), 1);
    do_req(3'b110);
    RST = 1'b1;
    @(negedge VCLK);
    chk_reset_outputs("rst_mid");
    RST = 1'b0;
    do_fb(2'b10, 1'b0, 3'b000);
    do_fb(2'b10, 1'b0, 3'b000);
    chk("rst_no_push", int'(cfg_valid), 0);
    do_fb(2'b10, 1'b0, 3'b000);
    chk("rst_no_push_late", int'(cfg_valid), 0);
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
